// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard/stall controller with multi-cycle data-memory freeze
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   id_rs, id_rt                  IF/ID source registers
//   id_branch, id_jump, br_taken  ID-stage control-flow information
//   ex_memr, ex_regwr, ex_rd      ID/EX load / register-write / destination
//   mem_memr, mem_acc, mem_rd     EX/MEM load / memory access / destination
//   pc_wr, ifid_wr, idex_wr, exmem_wr       pipeline register write-enables
//   ifid_flush, idex_flush, memwb_flush     bubble insertion
//   frozen                        memory freeze active this cycle
//   stall_cycles, flush_count     saturating statistics (only with HAZARD_STATS_EN)
// Optional feature macro: HAZARD_STATS_EN
module hazard_ctrl #(
    parameter int RW      = 5,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_branch,
    input  logic          id_jump,
    input  logic          br_taken,
    input  logic          ex_memr,
    input  logic          ex_regwr,
    input  logic [RW-1:0] ex_rd,
    input  logic          mem_memr,
    input  logic          mem_acc,
    input  logic [RW-1:0] mem_rd,
    output logic          pc_wr,
    output logic          ifid_wr,
    output logic          idex_wr,
    output logic          exmem_wr,
    output logic          ifid_flush,
    output logic          idex_flush,
    output logic          memwb_flush,
    output logic          frozen
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);
    localparam logic [1:0] RUN  = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [1:0] LOAD = 2'(MEM_LAT > 1 ? MEM_LAT - 2 : 0);

    if (MEM_LAT < 1 || MEM_LAT > 4 || CNT_W < 1) begin : g_bad_param
        $error("hazard_ctrl: illegal parameter value");
    end

    logic [1:0] r_state, r_cnt;
    logic       w_start, w_frz, w_ex_m, w_mem_m, w_stall, w_redir, w_flush;
    logic [1:0] w_state_nxt, w_cnt_nxt;

    // A new access is only recognised in RUN, so the access that follows
    // DONE starts a fresh freeze on its own cycle.
    assign w_start = (r_state == RUN) && mem_acc && (MEM_LAT > 1);
    assign w_frz   = w_start || (r_state == WAIT);

    always_comb begin
        w_state_nxt = (r_state == RUN)  ? (w_start ? ((MEM_LAT == 2) ? DONE : WAIT) : RUN) :
                      (r_state == WAIT) ? ((r_cnt == 2'd1) ? DONE : WAIT) : RUN;
        w_cnt_nxt   = w_start ? LOAD : (r_state == WAIT) ? r_cnt - 2'd1 : r_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Register 0 is hardwired, so it never creates a dependency.
    assign w_ex_m  = (ex_rd != '0) && (ex_rd == id_rs || ex_rd == id_rt);
    assign w_mem_m = (mem_rd != '0) && (mem_rd == id_rs || mem_rd == id_rt);
    assign w_stall = (ex_memr && w_ex_m) || (id_branch && ex_regwr && w_ex_m) ||
                     (id_branch && mem_memr && w_mem_m);
    assign w_redir = id_jump || (id_branch && br_taken);
    assign w_flush = !w_frz && !w_stall && w_redir;

    // Reset forces a bubble everywhere; freeze outranks every ID hazard.
    assign pc_wr       = !rst && !w_frz && !w_stall;
    assign ifid_wr     = !rst && !w_frz && !w_stall;
    assign idex_wr     = !rst && !w_frz;
    assign exmem_wr    = !rst && !w_frz;
    assign ifid_flush  = rst || w_flush;
    assign idex_flush  = rst || (!w_frz && w_stall);
    assign memwb_flush = rst || w_frz;
    assign frozen      = !rst && w_frz;

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] r_stall, r_flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall <= '0;
            r_flush <= '0;
        end else begin
            if ((w_frz || w_stall) && !(&r_stall)) r_stall <= r_stall + CNT_W'(1);
            if (w_flush && !(&r_flush)) r_flush <= r_flush + CNT_W'(1);
        end
    end

    assign stall_cycles = r_stall;
    assign flush_count  = r_flush;
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: self-checking bench for hazard_ctrl at MEM_LAT 1..4
module tb_hazard_ctrl;
    logic       clk = 1'b0, rst = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, ex_rd = '0, mem_rd = '0;
    logic       id_branch = 0, id_jump = 0, br_taken = 0;
    logic       ex_memr = 0, ex_regwr = 0, mem_memr = 0, mem_acc = 0;
    // {pc_wr, ifid_wr, idex_wr, exmem_wr, ifid_flush, idex_flush, memwb_flush, frozen}
    logic [7:0] act [4];
`ifdef HAZARD_STATS_EN
    logic [1:0] sc [4];
    logic [1:0] fc [4];
`endif
    int tests = 0, fails = 0;
    int rem [4];
    bit done [4];
    int m_sc [4], m_fc [4];

    localparam logic [7:0] V_RST = 8'h0E, V_FRZ = 8'h03, V_STL = 8'h34,
                           V_RED = 8'hF8, V_RUN = 8'hF0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : gl
        logic pw, iw, xw, ew, ifl, xfl, mfl, fz;
        hazard_ctrl #(.RW(5), .MEM_LAT(g + 1), .CNT_W(2)) u (
            .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
            .id_branch(id_branch), .id_jump(id_jump), .br_taken(br_taken),
            .ex_memr(ex_memr), .ex_regwr(ex_regwr), .ex_rd(ex_rd),
            .mem_memr(mem_memr), .mem_acc(mem_acc), .mem_rd(mem_rd),
            .pc_wr(pw), .ifid_wr(iw), .idex_wr(xw), .exmem_wr(ew),
            .ifid_flush(ifl), .idex_flush(xfl), .memwb_flush(mfl), .frozen(fz)
`ifdef HAZARD_STATS_EN
            , .stall_cycles(sc[g]), .flush_count(fc[g])
`endif
        );
        assign act[g] = {pw, iw, xw, ew, ifl, xfl, mfl, fz};
    end

    // Reference model: freeze tracked as "cycles of freeze still owed" plus
    // a one-cycle completion slot during which new accesses are ignored.
    function automatic bit fz_now(int k);
        if (rst || done[k]) return 1'b0;
        if (rem[k] > 0) return 1'b1;
        return mem_acc && k > 0;
    endfunction

    function automatic bit hit(logic [4:0] rd);
        return rd != 0 && (rd == id_rs || rd == id_rt);
    endfunction

    function automatic bit stall_now();
        return (ex_memr && hit(ex_rd)) || (id_branch && ex_regwr && hit(ex_rd)) ||
               (id_branch && mem_memr && hit(mem_rd));
    endfunction

    function automatic bit redir_now();
        return id_jump || (id_branch && br_taken);
    endfunction

    function automatic logic [7:0] expv(int k);
        return rst ? V_RST : fz_now(k) ? V_FRZ : stall_now() ? V_STL :
               redir_now() ? V_RED : V_RUN;
    endfunction

    task automatic adv();
        for (int k = 0; k < 4; k++) begin
            if (rst) begin
                rem[k] = 0; done[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
            end else begin
                bit f = fz_now(k);
                bit s = stall_now();
                if ((f || s) && m_sc[k] < 3) m_sc[k]++;
                if (!f && !s && redir_now() && m_fc[k] < 3) m_fc[k]++;
                if (done[k]) done[k] = 0;
                else if (rem[k] > 0) begin
                    rem[k]--;
                    if (rem[k] == 0) done[k] = 1;
                end else if (mem_acc && k > 0) begin
                    rem[k] = k - 1;
                    if (rem[k] == 0) done[k] = 1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; id_rs = 0; id_rt = 0; ex_rd = 0; mem_rd = 0;
        id_branch = 0; id_jump = 0; br_taken = 0;
        ex_memr = 0; ex_regwr = 0; mem_memr = 0; mem_acc = 0;
    endtask

    task automatic settle();
        idle();
        repeat (5) adv();
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            rst = 1; mem_acc = 1; id_jump = 1; ex_memr = 1; ex_rd = 3; id_rs = 3;
            #1;
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (act[k] !== V_RST) begin
                    fails++; $display("FAIL reset lat%0d got=%h exp=%h", k + 1, act[k], V_RST);
                end
            end
            adv();
        end
        settle();
    endtask

    task automatic test_load_use();
        logic [7:0] e [3] = '{V_STL, V_RUN, V_STL};
        settle();
        for (int c = 0; c < 3; c++) begin
            ex_memr = 1; ex_rd = (c == 1) ? 5'd0 : 5'd8;
            id_rs = (c == 2) ? 5'd0 : 5'd8; id_rt = (c == 2) ? 5'd8 : 5'd0;
            #1;
            tests++;
            if (act[0] !== e[c]) begin
                fails++; $display("FAIL load_use c%0d got=%h exp=%h", c, act[0], e[c]);
            end
            adv();
        end
    endtask

    task automatic test_branch_after_load();
        logic [7:0] e [3] = '{V_STL, V_STL, V_RED};
        settle();
        id_branch = 1; id_rt = 9;
        ex_memr = 1; ex_regwr = 1; ex_rd = 9;
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                ex_memr = 0; ex_regwr = 0; ex_rd = 0; mem_memr = 1; mem_rd = 9; mem_acc = 1;
            end
            if (c == 2) begin
                mem_memr = 0; mem_rd = 0; mem_acc = 0; br_taken = 1;
            end
            #1;
            tests++;
            if (act[0] !== e[c]) begin
                fails++; $display("FAIL branch_load c%0d got=%h exp=%h", c, act[0], e[c]);
            end
            adv();
        end
    endtask

    task automatic test_freeze_lat3();
        logic [7:0] e [4] = '{V_FRZ, V_FRZ, V_RUN, V_RUN};
        settle();
        for (int c = 0; c < 4; c++) begin
            mem_acc = (c == 0);
            #1;
            tests++;
            if (act[2] !== e[c]) begin
                fails++; $display("FAIL freeze_lat3 c%0d got=%h exp=%h", c, act[2], e[c]);
            end
            adv();
        end
    endtask

    task automatic test_freeze_override();
        logic [7:0] e2 [4] = '{V_FRZ, V_FRZ, V_STL, V_STL};
        logic [7:0] e3 [4] = '{V_FRZ, V_FRZ, V_FRZ, V_STL};
        settle();
        ex_memr = 1; ex_rd = 8; id_rs = 8; id_jump = 1;
        for (int c = 0; c < 4; c++) begin
            mem_acc = (c == 0);
            #1;
            tests += 2;
            if (act[2] !== e2[c]) begin
                fails++; $display("FAIL override_lat3 c%0d got=%h exp=%h", c, act[2], e2[c]);
            end
            if (act[3] !== e3[c]) begin
                fails++; $display("FAIL override_lat4 c%0d got=%h exp=%h", c, act[3], e3[c]);
            end
            adv();
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] pat = 6'b011011;
        settle();
        mem_acc = 1;
        for (int c = 0; c < 6; c++) begin
            #1;
            tests++;
            if (act[2][0] !== pat[c]) begin
                fails++; $display("FAIL back_to_back c%0d frozen=%b exp=%b", c, act[2][0], pat[c]);
            end
            adv();
        end
    endtask

    task automatic test_reset_in_wait();
        logic [7:0] e [4] = '{V_FRZ, V_RST, V_RUN, V_RUN};
        settle();
        for (int c = 0; c < 4; c++) begin
            mem_acc = (c == 0); rst = (c == 1);
            #1;
            tests++;
            if (act[3] !== e[c]) begin
                fails++; $display("FAIL reset_in_wait c%0d got=%h exp=%h", c, act[3], e[c]);
            end
            adv();
        end
    endtask

`ifdef HAZARD_STATS_EN
    task automatic test_stats();
        idle(); rst = 1; adv();
        idle(); ex_memr = 1; ex_rd = 4; id_rt = 4;
        for (int c = 0; c < 5; c++) begin
            #1;
            tests++;
            if (sc[0] !== 2'(c < 3 ? c : 3)) begin
                fails++; $display("FAIL stats_ramp c%0d got=%0d exp=%0d", c, sc[0], (c < 3 ? c : 3));
            end
            adv();
        end
        idle(); #1;
        tests += 2;
        if (sc[0] !== 2'd3) begin
            fails++; $display("FAIL stats_sat got=%0d exp=3", sc[0]);
        end
        if (fc[0] !== 2'd0) begin
            fails++; $display("FAIL stats_flush got=%0d exp=0", fc[0]);
        end
        adv();
    endtask
`endif

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 49) == 0);
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
            id_branch = 1'($urandom); id_jump = ($urandom_range(0, 3) == 0);
            br_taken = 1'($urandom); ex_memr = 1'($urandom); ex_regwr = 1'($urandom);
            mem_memr = 1'($urandom); mem_acc = ($urandom_range(0, 2) == 0);
            #1;
            for (int k = 0; k < 4; k++) begin
                tests++;
                if (act[k] !== expv(k)) begin
                    fails++; $display("FAIL random n%0d lat%0d got=%h exp=%h", n, k + 1, act[k], expv(k));
                end
`ifdef HAZARD_STATS_EN
                tests++;
                if (sc[k] !== 2'(m_sc[k]) || fc[k] !== 2'(m_fc[k])) begin
                    fails++; $display("FAIL random_stats n%0d lat%0d got=%0d/%0d exp=%0d/%0d",
                                      n, k + 1, sc[k], fc[k], m_sc[k], m_fc[k]);
                end
`endif
            end
            adv();
        end
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            rem[k] = 0; done[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
        end
        @(negedge clk);
        test_reset();
        test_load_use();
        test_branch_after_load();
        test_freeze_lat3();
        test_freeze_override();
        test_back_to_back();
        test_reset_in_wait();
`ifdef HAZARD_STATS_EN
        test_stats();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
